stream_slave_checker: RTL and testbench



---
 rtl/stream_sim_pkg.sv | 19 +
 rtl/stream_ready_shaper.sv | 42 ++++
 rtl/stream_slave_checker.sv | 178 +++++++++++++++++
 tb/tb_stream_slave_checker.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_sim_pkg.sv
// Shared definitions for the simulation-side AXI-Stream sink/checker.
package stream_sim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int          ID_W        = 5;
  localparam logic [31:0] NO_ERR_BEAT = 32'hFFFF_FFFF;

  // Error counters stop at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/stream_ready_shaper.sv
// Registered tready generator with periodic one-cycle backpressure.
module stream_ready_shaper
  import stream_sim_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_enable,
  input  logic [31:0] i_stall_period,
  output logic        o_tready
);

  logic [31:0] r_highCnt;
  logic        r_tready;

  // Count high cycles; after stall_period of them insert one low cycle and restart.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tready  <= 1'b0;
      r_highCnt <= 32'd0;
    end else if (!i_enable) begin
      r_tready  <= 1'b0;
      r_highCnt <= 32'd0;
    end else if (i_stall_period == 32'd0) begin
      r_tready  <= 1'b1;
      r_highCnt <= 32'd0;
    end else if (r_tready) begin
      if (r_highCnt == i_stall_period - 32'd1) begin
        r_tready  <= 1'b0;
        r_highCnt <= 32'd0;
      end else begin
        r_tready  <= 1'b1;
        r_highCnt <= r_highCnt + 32'd1;
      end
    end else begin
      r_tready  <= 1'b1;
      r_highCnt <= 32'd0;
    end
  end

  assign o_tready = r_tready;

endmodule

// File: rtl/stream_slave_checker.sv
// AXI-Stream sink that checks data pattern, tlast position, tid sequence,
// tdest and tkeep of every accepted beat, and counts packets and errors.
module stream_slave_checker
  import stream_sim_pkg::*;
#(
  parameter int TBYTE_NUM = 16
)
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [ID_W-1:0]        exp_dest,
  input  logic [31:0]            exp_pkt_num,
  input  logic [31:0]            exp_pkt_len,
  input  logic [TBYTE_NUM*8-1:0] start_from,
  input  logic [TBYTE_NUM*8-1:0] inc,
  input  logic                   fix,
  input  logic [31:0]            stall_period,
  input  logic                   check_start,
  output logic                   check_busy,
  output logic                   check_done,
  output logic                   err_flag,
  output logic [31:0]            pkt_cnt,
  output logic [31:0]            beat_total,
  output logic [31:0]            data_err_cnt,
  output logic [31:0]            last_err_cnt,
  output logic [31:0]            id_err_cnt,
  output logic [31:0]            first_err_beat,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [TBYTE_NUM*8-1:0] s_axis_tdata,
  input  logic [TBYTE_NUM-1:0]   s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic [ID_W-1:0]        s_axis_tid,
  input  logic [ID_W-1:0]        s_axis_tdest
);

  state_t                 r_state;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_errFlag;
  logic [31:0]            r_pktCnt;
  logic [31:0]            r_beatTotal;
  logic [31:0]            r_dataErrCnt;
  logic [31:0]            r_lastErrCnt;
  logic [31:0]            r_idErrCnt;
  logic [31:0]            r_firstErrBeat;
  logic [31:0]            r_beatInPkt;
  logic [TBYTE_NUM*8-1:0] r_expData;
  logic [ID_W-1:0]        r_expTid;

  logic                   w_tready;
  logic                   w_accept;
  logic                   w_zeroCfg;
  logic                   w_finalAccept;
  logic                   w_shaperEnable;
  logic [31:0]            w_lenM1;
  logic                   w_dataErr;
  logic                   w_idErr;
  logic                   w_lastErr;
  logic                   w_anyErr;

  // Per-beat checks are purely combinational on the accepted beat.
  always_comb begin
    w_accept       = s_axis_tvalid & w_tready & (r_state == ST_RUN);
    w_zeroCfg      = (exp_pkt_num == 32'd0) || (exp_pkt_len == 32'd0);
    w_finalAccept  = w_accept & s_axis_tlast & ((r_pktCnt + 32'd1) == exp_pkt_num);
    // tready must already be low the cycle after the final tlast, so the
    // shaper is driven by where the FSM is heading, not where it is.
    w_shaperEnable = ((r_state == ST_ARM) && !w_zeroCfg) ||
                     ((r_state == ST_RUN) && !w_finalAccept);
    w_lenM1        = exp_pkt_len - 32'd1;
    w_dataErr      = (s_axis_tdata != r_expData) || (s_axis_tkeep != {TBYTE_NUM{1'b1}});
    w_idErr        = (s_axis_tid != r_expTid) || (s_axis_tdest != exp_dest);
    w_lastErr      = s_axis_tlast ? (r_beatInPkt < w_lenM1) : (r_beatInPkt == w_lenM1);
    w_anyErr       = w_dataErr | w_idErr | w_lastErr;
  end

  stream_ready_shaper u_shaper (
    .clk            (clk),
    .rstn           (rstn),
    .i_enable       (w_shaperEnable),
    .i_stall_period (stall_period),
    .o_tready       (w_tready)
  );

  // Checker FSM together with its counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state        <= ST_IDLE;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_errFlag      <= 1'b0;
      r_pktCnt       <= 32'd0;
      r_beatTotal    <= 32'd0;
      r_dataErrCnt   <= 32'd0;
      r_lastErrCnt   <= 32'd0;
      r_idErrCnt     <= 32'd0;
      r_firstErrBeat <= NO_ERR_BEAT;
      r_beatInPkt    <= 32'd0;
      r_expData      <= '0;
      r_expTid       <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (check_start) begin
            r_state <= ST_ARM;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_ARM: begin
          r_errFlag      <= 1'b0;
          r_pktCnt       <= 32'd0;
          r_beatTotal    <= 32'd0;
          r_dataErrCnt   <= 32'd0;
          r_lastErrCnt   <= 32'd0;
          r_idErrCnt     <= 32'd0;
          r_firstErrBeat <= NO_ERR_BEAT;
          r_beatInPkt    <= 32'd0;
          r_expData      <= start_from;
          r_expTid       <= '0;
          if (w_zeroCfg) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_beatTotal <= r_beatTotal + 32'd1;
            if (w_dataErr) r_dataErrCnt <= satInc(r_dataErrCnt);
            if (w_idErr)   r_idErrCnt   <= satInc(r_idErrCnt);
            if (w_lastErr) r_lastErrCnt <= satInc(r_lastErrCnt);
            if (w_anyErr) begin
              r_errFlag <= 1'b1;
              if (r_firstErrBeat == NO_ERR_BEAT) r_firstErrBeat <= r_beatTotal;
            end
            // The received tlast defines the packet boundary so a faulty
            // stream resynchronises on its next packet.
            if (s_axis_tlast) begin
              r_pktCnt    <= r_pktCnt + 32'd1;
              r_expTid    <= r_expTid + 1'b1;
              r_beatInPkt <= 32'd0;
              r_expData   <= start_from;
            end else begin
              r_beatInPkt <= r_beatInPkt + 32'd1;
              r_expData   <= fix ? start_from : r_expData + inc;
            end
            if (w_finalAccept) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign check_busy     = r_busy;
  assign check_done     = r_done;
  assign err_flag       = r_errFlag;
  assign pkt_cnt        = r_pktCnt;
  assign beat_total     = r_beatTotal;
  assign data_err_cnt   = r_dataErrCnt;
  assign last_err_cnt   = r_lastErrCnt;
  assign id_err_cnt     = r_idErrCnt;
  assign first_err_beat = r_firstErrBeat;
  assign s_axis_tready  = w_tready;

endmodule

// File: tb/tb_stream_slave_checker.sv
// Self-checking bench for stream_slave_checker: directed scenarios plus
// randomized streams compared against a packet-level reference model.
module tb_stream_slave_checker;

  localparam int TB = 16;
  localparam int W  = TB * 8;

  logic          clk;
  logic          rstn;
  logic [4:0]    exp_dest;
  logic [31:0]   exp_pkt_num;
  logic [31:0]   exp_pkt_len;
  logic [W-1:0]  start_from;
  logic [W-1:0]  inc;
  logic          fix;
  logic [31:0]   stall_period;
  logic          check_start;
  logic          check_busy;
  logic          check_done;
  logic          err_flag;
  logic [31:0]   pkt_cnt;
  logic [31:0]   beat_total;
  logic [31:0]   data_err_cnt;
  logic [31:0]   last_err_cnt;
  logic [31:0]   id_err_cnt;
  logic [31:0]   first_err_beat;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [W-1:0]  s_axis_tdata;
  logic [TB-1:0] s_axis_tkeep;
  logic          s_axis_tlast;
  logic [4:0]    s_axis_tid;
  logic [4:0]    s_axis_tdest;

  typedef struct {
    logic [W-1:0]  data;
    logic [TB-1:0] keep;
    logic          last;
    logic [4:0]    tid;
    logic [4:0]    dest;
  } beat_t;

  typedef struct {
    logic [31:0] pkt;
    logic [31:0] beats;
    logic [31:0] dataE;
    logic [31:0] lastE;
    logic [31:0] idE;
    logic [31:0] firstE;
    logic        errFlag;
  } res_t;

  beat_t q[$];
  beat_t full[$];
  res_t  ex;
  int    checks   = 0;
  int    failures = 0;

  stream_slave_checker #(.TBYTE_NUM(TB)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .exp_dest       (exp_dest),
    .exp_pkt_num    (exp_pkt_num),
    .exp_pkt_len    (exp_pkt_len),
    .start_from     (start_from),
    .inc            (inc),
    .fix            (fix),
    .stall_period   (stall_period),
    .check_start    (check_start),
    .check_busy     (check_busy),
    .check_done     (check_done),
    .err_flag       (err_flag),
    .pkt_cnt        (pkt_cnt),
    .beat_total     (beat_total),
    .data_err_cnt   (data_err_cnt),
    .last_err_cnt   (last_err_cnt),
    .id_err_cnt     (id_err_cnt),
    .first_err_beat (first_err_beat),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tid     (s_axis_tid),
    .s_axis_tdest   (s_axis_tdest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Append one packet of L beats with sequence id p; faultPct injects random beat faults.
  task automatic add_packet(input int p, input int L, input int faultPct);
    for (int i = 0; i < L; i++) begin
      beat_t b;
      b.data = fix ? start_from : start_from + inc * W'(i);
      b.keep = '1;
      b.last = (i == L - 1);
      b.tid  = 5'(p);
      b.dest = exp_dest;
      if (int'($urandom_range(99)) < faultPct) begin
        case ($urandom_range(3))
          0: b.data = b.data ^ (W'(1) << $urandom_range(W - 1));
          1: b.keep = b.keep ^ (TB'(1) << $urandom_range(TB - 1));
          2: b.tid  = b.tid + 5'd1;
          default: b.dest = b.dest ^ 5'd4;
        endcase
      end
      q.push_back(b);
    end
  endtask

  task automatic build_clean();
    q.delete();
    for (int p = 0; p < int'(exp_pkt_num); p++) add_packet(p, int'(exp_pkt_len), 0);
  endtask

  // Reference: walk the offered beats packet by packet; position inside the
  // received packet gives the expected data, received packet count the tid.
  function automatic res_t model();
    res_t r;
    logic [31:0] pos;
    r = '{pkt: 0, beats: 0, dataE: 0, lastE: 0, idE: 0, firstE: 32'hFFFF_FFFF, errFlag: 1'b0};
    pos = 0;
    foreach (q[i]) begin
      logic [W-1:0] e;
      bit dE, iE, lE;
      e  = fix ? start_from : start_from + inc * W'(pos);
      dE = (q[i].data !== e) || (q[i].keep !== {TB{1'b1}});
      iE = (q[i].tid !== r.pkt[4:0]) || (q[i].dest !== exp_dest);
      lE = q[i].last ? (pos < exp_pkt_len - 1) : (pos == exp_pkt_len - 1);
      if (dE) r.dataE++;
      if (iE) r.idE++;
      if (lE) r.lastE++;
      if (dE || iE || lE) begin
        r.errFlag = 1'b1;
        if (r.firstE == 32'hFFFF_FFFF) r.firstE = r.beats;
      end
      r.beats++;
      if (q[i].last) begin
        r.pkt++;
        pos = 0;
        if (r.pkt == exp_pkt_num) break;
      end else begin
        pos++;
      end
    end
    return r;
  endfunction

  task automatic arm();
    @(negedge clk) check_start = 1'b1;
    @(negedge clk) check_start = 1'b0;
  endtask

  // Drive the queued beats with random idle gaps, honouring tready.
  task automatic applyStimulus(input int gapPct);
    foreach (q[i]) begin
      int n;
      @(negedge clk) s_axis_tvalid = 1'b0;
      while (int'($urandom_range(99)) < gapPct) @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = q[i].data;
      s_axis_tkeep  = q[i].keep;
      s_axis_tlast  = q[i].last;
      s_axis_tid    = q[i].tid;
      s_axis_tdest  = q[i].dest;
      n = 0;
      while (!s_axis_tready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!s_axis_tready) begin
        checks++; failures++;
        $display("FAIL drive.tready_timeout beat=%0d got tready=0 exp=1", i);
        s_axis_tvalid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk) s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!check_done && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({pkt_cnt, beat_total, data_err_cnt, last_err_cnt, id_err_cnt} !== '0) begin failures++; $display("FAIL reset.counters got=%0d/%0d/%0d/%0d/%0d exp=0", pkt_cnt, beat_total, data_err_cnt, last_err_cnt, id_err_cnt); end
    checks++; if (first_err_beat !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset.first_err_beat got=%h exp=ffffffff", first_err_beat); end
    checks++; if ({err_flag, s_axis_tready, check_busy, check_done} !== 4'b0) begin failures++; $display("FAIL reset.flags got=%b exp=0000", {err_flag, s_axis_tready, check_busy, check_done}); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean();
    start_from = '0; inc = W'(1); fix = 1'b0; exp_dest = 5'd3;
    exp_pkt_len = 4; exp_pkt_num = 3; stall_period = 0;
    build_clean();
    ex = model();
    arm();
    checks++; if (check_busy !== 1'b1) begin failures++; $display("FAIL clean.busy_in_arm got=%b exp=1", check_busy); end
    applyStimulus(20);
    wait_done();
    checks++; if (check_done !== 1'b1) begin failures++; $display("FAIL clean.done got=%b exp=1", check_done); end
    checks++; if (pkt_cnt !== ex.pkt) begin failures++; $display("FAIL clean.pkt_cnt got=%0d exp=%0d", pkt_cnt, ex.pkt); end
    checks++; if (beat_total !== ex.beats) begin failures++; $display("FAIL clean.beat_total got=%0d exp=%0d", beat_total, ex.beats); end
    checks++; if ({data_err_cnt, last_err_cnt, id_err_cnt} !== {ex.dataE, ex.lastE, ex.idE}) begin failures++; $display("FAIL clean.err_cnts got=%0d/%0d/%0d exp=%0d/%0d/%0d", data_err_cnt, last_err_cnt, id_err_cnt, ex.dataE, ex.lastE, ex.idE); end
    checks++; if (first_err_beat !== ex.firstE) begin failures++; $display("FAIL clean.first_err_beat got=%h exp=%h", first_err_beat, ex.firstE); end
    checks++; if (err_flag !== ex.errFlag) begin failures++; $display("FAIL clean.err_flag got=%b exp=%b", err_flag, ex.errFlag); end
    // Beats offered in DONE must be ignored.
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL clean.tready_in_done got=%b exp=0", s_axis_tready); end
    checks++; if (beat_total !== ex.beats) begin failures++; $display("FAIL clean.no_count_in_done got=%0d exp=%0d", beat_total, ex.beats); end
    s_axis_tvalid = 1'b0;
    // Zero packets requested goes straight to DONE with cleared counters.
    exp_pkt_num = 0;
    arm();
    @(negedge clk);
    checks++; if ({check_busy, check_done} !== 2'b01) begin failures++; $display("FAIL zero.busy_done got=%b exp=01", {check_busy, check_done}); end
    checks++; if (beat_total !== 32'd0) begin failures++; $display("FAIL zero.beat_total got=%0d exp=0", beat_total); end
  endtask

  task automatic test_stall();
    exp_pkt_num = 3; exp_pkt_len = 4; stall_period = 3;
    build_clean();
    ex = model();
    arm();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++; if (s_axis_tready !== ((k % 4) != 3)) begin failures++; $display("FAIL stall.pattern cycle=%0d got=%b exp=%b", k, s_axis_tready, ((k % 4) != 3)); end
    end
    applyStimulus(0);
    wait_done();
    checks++; if (beat_total !== ex.beats) begin failures++; $display("FAIL stall.beat_total got=%0d exp=%0d", beat_total, ex.beats); end
    checks++; if ({pkt_cnt, data_err_cnt, last_err_cnt, id_err_cnt} !== {ex.pkt, ex.dataE, ex.lastE, ex.idE}) begin failures++; $display("FAIL stall.counts got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", pkt_cnt, data_err_cnt, last_err_cnt, id_err_cnt, ex.pkt, ex.dataE, ex.lastE, ex.idE); end
    checks++; if (err_flag !== ex.errFlag) begin failures++; $display("FAIL stall.err_flag got=%b exp=%b", err_flag, ex.errFlag); end
    stall_period = 0;
  endtask

  task automatic test_data_err();
    build_clean();
    q[2].data = W'(8'h55);
    ex = model();
    arm();
    applyStimulus(10);
    wait_done();
    checks++; if (data_err_cnt !== ex.dataE) begin failures++; $display("FAIL data.data_err_cnt got=%0d exp=%0d", data_err_cnt, ex.dataE); end
    checks++; if (first_err_beat !== ex.firstE) begin failures++; $display("FAIL data.first_err_beat got=%0d exp=%0d", first_err_beat, ex.firstE); end
    checks++; if (err_flag !== ex.errFlag) begin failures++; $display("FAIL data.err_flag got=%b exp=%b", err_flag, ex.errFlag); end
    checks++; if ({last_err_cnt, id_err_cnt, pkt_cnt} !== {ex.lastE, ex.idE, ex.pkt}) begin failures++; $display("FAIL data.others got=%0d/%0d/%0d exp=%0d/%0d/%0d", last_err_cnt, id_err_cnt, pkt_cnt, ex.lastE, ex.idE, ex.pkt); end
  endtask

  task automatic test_last_err();
    q.delete();
    add_packet(0, 4, 0);
    add_packet(1, 2, 0);
    add_packet(2, 4, 0);
    ex = model();
    arm();
    applyStimulus(10);
    wait_done();
    checks++; if (last_err_cnt !== ex.lastE) begin failures++; $display("FAIL last.last_err_cnt got=%0d exp=%0d", last_err_cnt, ex.lastE); end
    checks++; if ({data_err_cnt, id_err_cnt} !== {ex.dataE, ex.idE}) begin failures++; $display("FAIL last.resync got=%0d/%0d exp=%0d/%0d", data_err_cnt, id_err_cnt, ex.dataE, ex.idE); end
    checks++; if ({pkt_cnt, beat_total, first_err_beat} !== {ex.pkt, ex.beats, ex.firstE}) begin failures++; $display("FAIL last.totals got=%0d/%0d/%0d exp=%0d/%0d/%0d", pkt_cnt, beat_total, first_err_beat, ex.pkt, ex.beats, ex.firstE); end
  endtask

  task automatic test_tid_wrap();
    start_from = {$urandom, $urandom, $urandom, $urandom};
    inc        = {$urandom, $urandom, $urandom, $urandom};
    exp_dest = 5'd3; exp_pkt_num = 40; exp_pkt_len = 2;
    build_clean();
    q[70].dest = 5'd7;
    ex = model();
    arm();
    applyStimulus(0);
    wait_done();
    checks++; if (id_err_cnt !== ex.idE) begin failures++; $display("FAIL tid.id_err_cnt got=%0d exp=%0d", id_err_cnt, ex.idE); end
    checks++; if (first_err_beat !== ex.firstE) begin failures++; $display("FAIL tid.first_err_beat got=%0d exp=%0d", first_err_beat, ex.firstE); end
    checks++; if ({pkt_cnt, beat_total, data_err_cnt, last_err_cnt} !== {ex.pkt, ex.beats, ex.dataE, ex.lastE}) begin failures++; $display("FAIL tid.totals got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", pkt_cnt, beat_total, data_err_cnt, last_err_cnt, ex.pkt, ex.beats, ex.dataE, ex.lastE); end
  endtask

  task automatic test_reset_midrun();
    start_from = '0; inc = W'(1); exp_pkt_num = 3; exp_pkt_len = 4;
    build_clean();
    full = q;
    q = full[0:4];
    ex = model();
    arm();
    applyStimulus(0);
    checks++; if ({pkt_cnt, beat_total} !== {ex.pkt, ex.beats}) begin failures++; $display("FAIL midrun.progress got=%0d/%0d exp=%0d/%0d", pkt_cnt, beat_total, ex.pkt, ex.beats); end
    @(negedge clk) rstn = 1'b0;
    @(negedge clk) rstn = 1'b1;
    checks++; if ({pkt_cnt, beat_total, data_err_cnt, last_err_cnt, id_err_cnt} !== '0) begin failures++; $display("FAIL midrun.counters got=%0d/%0d/%0d/%0d/%0d exp=0", pkt_cnt, beat_total, data_err_cnt, last_err_cnt, id_err_cnt); end
    checks++; if ({err_flag, s_axis_tready, check_busy, check_done, first_err_beat} !== {4'b0, 32'hFFFF_FFFF}) begin failures++; $display("FAIL midrun.flags got=%b/%h exp=0000/ffffffff", {err_flag, s_axis_tready, check_busy, check_done}, first_err_beat); end
    q = full;
    ex = model();
    arm();
    applyStimulus(15);
    wait_done();
    checks++; if ({check_done, err_flag} !== {1'b1, ex.errFlag}) begin failures++; $display("FAIL midrun.rearm_flags got=%b exp=%b", {check_done, err_flag}, {1'b1, ex.errFlag}); end
    checks++; if ({pkt_cnt, beat_total, data_err_cnt, last_err_cnt, id_err_cnt} !== {ex.pkt, ex.beats, ex.dataE, ex.lastE, ex.idE}) begin failures++; $display("FAIL midrun.rearm_counts got=%0d/%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d/%0d", pkt_cnt, beat_total, data_err_cnt, last_err_cnt, id_err_cnt, ex.pkt, ex.beats, ex.dataE, ex.lastE, ex.idE); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      start_from   = {$urandom, $urandom, $urandom, $urandom};
      inc          = {$urandom, $urandom, $urandom, $urandom};
      fix          = 1'($urandom_range(1));
      exp_dest     = 5'($urandom_range(31));
      exp_pkt_len  = $urandom_range(1, 5);
      exp_pkt_num  = $urandom_range(1, 6);
      stall_period = $urandom_range(0, 4);
      q.delete();
      for (int p = 0; p < int'(exp_pkt_num); p++) begin
        int L = int'(exp_pkt_len);
        int r = int'($urandom_range(9));
        if (r == 0 && L > 1) L = L - 1;
        else if (r == 1) L = L + 1;
        add_packet(p, L, 6);
      end
      ex = model();
      arm();
      applyStimulus(30);
      wait_done();
      checks++; if ({check_done, err_flag} !== {1'b1, ex.errFlag}) begin failures++; $display("FAIL rand%0d.flags got=%b exp=%b", it, {check_done, err_flag}, {1'b1, ex.errFlag}); end
      checks++; if ({pkt_cnt, beat_total} !== {ex.pkt, ex.beats}) begin failures++; $display("FAIL rand%0d.totals got=%0d/%0d exp=%0d/%0d", it, pkt_cnt, beat_total, ex.pkt, ex.beats); end
      checks++; if ({data_err_cnt, last_err_cnt, id_err_cnt} !== {ex.dataE, ex.lastE, ex.idE}) begin failures++; $display("FAIL rand%0d.err_cnts got=%0d/%0d/%0d exp=%0d/%0d/%0d", it, data_err_cnt, last_err_cnt, id_err_cnt, ex.dataE, ex.lastE, ex.idE); end
      checks++; if (first_err_beat !== ex.firstE) begin failures++; $display("FAIL rand%0d.first_err_beat got=%h exp=%h", it, first_err_beat, ex.firstE); end
    end
  endtask

  initial begin
    rstn = 1'b0; check_start = 1'b0; fix = 1'b0;
    exp_dest = '0; exp_pkt_num = '0; exp_pkt_len = '0;
    start_from = '0; inc = '0; stall_period = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tlast = 1'b0; s_axis_tid = '0; s_axis_tdest = '0;
    test_reset();
    test_clean();
    test_stall();
    test_data_err();
    test_last_err();
    test_tid_wrap();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
